// File: rtl/lfsr_pkg.sv
// Shared types and tap constants for the parametrised Fibonacci LFSR keystream generator.
package lfsr_pkg;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      PRIME    = 2'd1,
      RUN      = 2'd2
   } lfsr_state_e;

   // x^128 + x^7 + x^2 + x + 1
   localparam logic [127:0] TAPS_128    = 128'h87;
   localparam logic [7:0]   TAPS_TEST_8 = 8'h71;

endpackage : lfsr_pkg

// File: rtl/lfsr_step_n.sv
// Combinational N-step advance of a Fibonacci LFSR: fb = ^(s & TAPS), s' = {fb, s[WIDTH-1:1]}.
module lfsr_step_n
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 128,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_128),
   parameter int unsigned      N     = 8
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] state_c_o
);

   logic [WIDTH-1:0] s;

   // Unrolled chain of single steps; bit 0 of each intermediate is the bit shifted out.
   always_comb begin
      s = state_i;
      for (int unsigned i = 0; i < N; i++) begin
         s = {^(s & TAPS), s[WIDTH-1:1]};
      end
      state_c_o = s;
   end

endmodule : lfsr_step_n

// File: rtl/lfsr_prng_stream.sv
// LFSR keystream source: runtime seeding with zero rejection, OUT_W bits per valid/ready transfer.
module lfsr_prng_stream
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 128,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_128),
   parameter int unsigned      OUT_W = 8,
   parameter int unsigned      CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed,
   output logic             o_seed_err,
   output logic             o_seeded,
   output logic [OUT_W-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_word_cnt
);

   lfsr_state_e      state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] lfsr_adv;
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seeded_q, seeded_d;
   logic             seed_err_q, seed_err_d;
   logic             xfer;
   logic             seed_ok;
   logic             seed_zero;

   lfsr_step_n #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .N     (OUT_W)
   ) u_step (
      .state_i   (lfsr_q),
      .state_c_o (lfsr_adv)
   );

   assign xfer      = valid_q & i_ready;
   assign seed_ok   = i_seed_load & (i_seed != '0);
   assign seed_zero = i_seed_load & (i_seed == '0);

   // Next-state: stream FSM first, then an accepted seed overrides it (after the transfer is counted).
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      seeded_d   = seeded_q;
      seed_err_d = 1'b0;

      case (state_q)
         UNSEEDED: ;
         PRIME: begin
            data_d  = lfsr_q[OUT_W-1:0];
            lfsr_d  = lfsr_adv;
            valid_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (xfer) begin
               data_d = lfsr_q[OUT_W-1:0];
               lfsr_d = lfsr_adv;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = UNSEEDED;
      endcase

      if (seed_ok) begin
         lfsr_d   = i_seed;
         valid_d  = 1'b0;
         cnt_d    = '0;
         seeded_d = 1'b1;
         state_d  = PRIME;
      end

      if (seed_zero) begin
         seed_err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q    <= UNSEEDED;
         lfsr_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         seeded_q   <= 1'b0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         seeded_q   <= seeded_d;
         seed_err_q <= seed_err_d;
      end
   end

   assign o_data     = data_q;
   assign o_valid    = valid_q;
   assign o_word_cnt = cnt_q;
   assign o_seeded   = seeded_q;
   assign o_seed_err = seed_err_q;

endmodule : lfsr_prng_stream

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: 8-bit LFSR (taps 8'h71), 4-bit words, plus a 1-bit period instance.
module tb_lfsr_prng_stream;
   import lfsr_pkg::*;

   localparam int unsigned NBITS = 530;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [7:0]  seed;
   logic        ready;
   logic        seed_err;
   logic        seeded;
   logic [3:0]  data;
   logic        valid;
   logic [3:0]  cnt;

   logic        seed_load2;
   logic [7:0]  seed2;
   logic        ready2;
   logic        seed_err2;
   logic        seeded2;
   logic [0:0]  data2;
   logic        valid2;
   logic [15:0] cnt2;

   int          n_cmp = 0;
   int          n_mis = 0;

   logic [3:0]  sb_q[$];
   logic [7:0]  m_state;
   logic [3:0]  exp_cnt;
   logic        exp_seeded;

   always #5 clk = ~clk;

   lfsr_prng_stream #(
      .WIDTH (8),
      .TAPS  (TAPS_TEST_8),
      .OUT_W (4),
      .CNT_W (4)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_seed_load (seed_load),
      .i_seed      (seed),
      .o_seed_err  (seed_err),
      .o_seeded    (seeded),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_word_cnt  (cnt)
   );

   lfsr_prng_stream #(
      .WIDTH (8),
      .TAPS  (TAPS_TEST_8),
      .OUT_W (1),
      .CNT_W (16)
   ) dut_bit (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_seed_load (seed_load2),
      .i_seed      (seed2),
      .o_seed_err  (seed_err2),
      .o_seeded    (seeded2),
      .o_data      (data2),
      .o_valid     (valid2),
      .i_ready     (ready2),
      .o_word_cnt  (cnt2)
   );

   // Reference single step for taps 8'h71 (s[0], s[4], s[5], s[6])
   function automatic logic [7:0] m_step(input logic [7:0] s);
      return {s[0] ^ s[4] ^ s[5] ^ s[6], s[7:1]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(m_state[3:0]);
         for (int k = 0; k < 4; k++) m_state = m_step(m_state);
      end
   endtask

   // One clock: score any transfer about to happen, update the model from driven inputs, check after the edge.
   task automatic step();
      logic [3:0] e;
      logic       err_e;
      if (rst_n && valid && ready) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("word", 32'(data), 32'(e));
         end
         exp_cnt = exp_cnt + 4'd1;
      end
      err_e = rst_n && seed_load && (seed == 8'h00);
      if (!rst_n) begin
         exp_cnt    = 4'd0;
         exp_seeded = 1'b0;
         sb_q.delete();
      end else if (seed_load && seed != 8'h00) begin
         exp_cnt    = 4'd0;
         exp_seeded = 1'b1;
         sb_q.delete();
         m_state    = seed;
         push_words(40);
      end
      @(negedge clk);
      chk("cnt", 32'(cnt), 32'(exp_cnt));
      chk("seeded", 32'(seeded), 32'(exp_seeded));
      chk("seed_err", 32'(seed_err), 32'(err_e));
   endtask

   initial begin
      logic        bits [NBITS];
      logic [7:0]  m2;
      int          bad_valid;
      int          bad_model;
      int          bad_period;
      int          zero_win;
      int          has_diff;
      int          divs [7];

      rst_n      = 1'b0;
      seed_load  = 1'b0;
      seed       = 8'h00;
      ready      = 1'b0;
      seed_load2 = 1'b0;
      seed2      = 8'h00;
      ready2     = 1'b0;
      exp_cnt    = 4'd0;
      exp_seeded = 1'b0;
      m_state    = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_seeded", 32'(seeded), 32'd0);
      chk("rst_err", 32'(seed_err), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_valid2", 32'(valid2), 32'd0);
      rst_n = 1'b1;
      step();
      chk("unseeded_valid", 32'(valid), 32'd0);

      // Seed 8'h01 with ready high: words 1, 0, D; counter 1, 2, 3
      seed_load = 1'b1;
      seed      = 8'h01;
      ready     = 1'b1;
      step();
      seed_load = 1'b0;
      chk("prime_valid", 32'(valid), 32'd0);
      step();
      chk("valid_up", 32'(valid), 32'd1);
      chk("w1", 32'(data), 32'h1);
      step();
      chk("w2", 32'(data), 32'h0);
      step();
      chk("w3", 32'(data), 32'hD);
      step();
      chk("cnt3", 32'(cnt), 32'd3);
      repeat (13) step();
      chk("cnt_wrap", 32'(cnt), 32'd0);
      step();

      // Zero seed while running: one-cycle error pulse, stream undisturbed
      seed_load = 1'b1;
      seed      = 8'h00;
      step();
      seed_load = 1'b0;
      chk("zero_valid", 32'(valid), 32'd1);
      repeat (3) step();

      // Reseed 8'h01 with ready low: word held stable
      seed_load = 1'b1;
      seed      = 8'h01;
      ready     = 1'b0;
      step();
      seed_load = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_data", 32'(data), 32'h1);
         chk("hold_valid", 32'(valid), 32'd1);
      end
      ready = 1'b1;
      step();
      chk("resume", 32'(data), 32'h0);
      step();

      // Seed strobe together with a transfer
      seed_load = 1'b1;
      seed      = 8'hA5;
      step();
      seed_load = 1'b0;
      chk("sim_valid_drop", 32'(valid), 32'd0);
      step();
      chk("sim_valid_up", 32'(valid), 32'd1);
      chk("sim_first", 32'(data), 32'h5);
      repeat (3) step();

      // Reset mid-stream together with a seed load
      rst_n     = 1'b0;
      seed_load = 1'b1;
      seed      = 8'h3C;
      step();
      seed_load = 1'b0;
      rst_n     = 1'b1;
      chk("mrst_data", 32'(data), 32'd0);
      chk("mrst_valid", 32'(valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_word", 32'(valid), 32'd0);
      end

      // 1-bit instance: period 255, never all-zero state
      seed_load2 = 1'b1;
      seed2      = 8'h01;
      ready2     = 1'b1;
      @(negedge clk);
      seed_load2 = 1'b0;
      @(negedge clk);
      m2        = 8'h01;
      bad_valid = 0;
      bad_model = 0;
      for (int i = 0; i < int'(NBITS); i++) begin
         if (valid2 !== 1'b1) bad_valid++;
         bits[i] = data2[0];
         if (data2[0] !== m2[0]) bad_model++;
         m2 = m_step(m2);
         @(negedge clk);
      end
      chk("p_valid", 32'(bad_valid), 32'd0);
      chk("p_model", 32'(bad_model), 32'd0);
      chk("p_cnt", 32'(cnt2), 32'(NBITS));

      bad_period = 0;
      for (int i = 0; i < int'(NBITS) - 255; i++) begin
         if (bits[i] !== bits[i+255]) bad_period++;
      end
      chk("period255", 32'(bad_period), 32'd0);

      divs = '{1, 3, 5, 15, 17, 51, 85};
      for (int d = 0; d < 7; d++) begin
         has_diff = 0;
         for (int i = 0; i < 255; i++) begin
            if (bits[i] !== bits[i+divs[d]]) has_diff = 1;
         end
         chk($sformatf("not_period_%0d", divs[d]), 32'(has_diff), 32'd1);
      end

      // Eight consecutive output bits are the state, so an all-zero window means a zero state
      zero_win = 0;
      for (int i = 0; i <= int'(NBITS) - 8; i++) begin
         has_diff = 0;
         for (int k = 0; k < 8; k++) begin
            if (bits[i+k] !== 1'b0) has_diff = 1;
         end
         if (has_diff == 0) zero_win++;
      end
      chk("no_zero_state", 32'(zero_win), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_lfsr_prng_stream
